// File: rtl/id_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate types, control encodings,
// the ID/EX control record, and the combinational decoder / immediate generator.
package id_pkg;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

   localparam logic [2:0] ALU_ADD    = 3'd0;
   localparam logic [2:0] ALU_RTYPE  = 3'd1;
   localparam logic [2:0] ALU_ITYPE  = 3'd2;
   localparam logic [2:0] ALU_BRANCH = 3'd3;
   localparam logic [2:0] ALU_PASS_B = 3'd4;

   localparam logic [1:0] BR_NONE = 2'd0;
   localparam logic [1:0] BR_COND = 2'd1;
   localparam logic [1:0] BR_JAL  = 2'd2;
   localparam logic [1:0] BR_JALR = 2'd3;

   typedef struct packed {
      imm_type_e  imm_type;
      logic [2:0] alu_op;
      logic       alu_src;
      logic       pc_sel;
      logic [1:0] branch;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       uses_rs1;
      logic       uses_rs2;
   } ctrl_t;

   // Width-independent part of the ID/EX register; data and addresses live beside it.
   typedef struct packed {
      logic       valid;
      logic [2:0] funct3;
      logic [6:0] funct7;
      logic [2:0] alu_op;
      logic       alu_src;
      logic       pc_sel;
      logic [1:0] branch;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
   } id_ex_t;

   function automatic ctrl_t decode(input logic [6:0] opcode);
      ctrl_t c;
      c          = '0;
      c.imm_type = IMM_I;
      case (opcode)
         OP_R:     begin c.alu_op = ALU_RTYPE; c.reg_write = 1'b1;
                         c.uses_rs1 = 1'b1; c.uses_rs2 = 1'b1; end
         OP_I:     begin c.alu_op = ALU_ITYPE; c.alu_src = 1'b1; c.reg_write = 1'b1;
                         c.uses_rs1 = 1'b1; end
         OP_LOAD:  begin c.alu_src = 1'b1; c.mem_read = 1'b1; c.reg_write = 1'b1;
                         c.uses_rs1 = 1'b1; end
         OP_S:     begin c.imm_type = IMM_S; c.alu_src = 1'b1; c.mem_write = 1'b1;
                         c.uses_rs1 = 1'b1; c.uses_rs2 = 1'b1; end
         OP_B:     begin c.imm_type = IMM_B; c.alu_op = ALU_BRANCH; c.branch = BR_COND;
                         c.uses_rs1 = 1'b1; c.uses_rs2 = 1'b1; end
         OP_JAL:   begin c.imm_type = IMM_J; c.alu_src = 1'b1; c.pc_sel = 1'b1;
                         c.branch = BR_JAL; c.reg_write = 1'b1; end
         OP_JALR:  begin c.alu_src = 1'b1; c.pc_sel = 1'b1; c.branch = BR_JALR;
                         c.reg_write = 1'b1; c.uses_rs1 = 1'b1; end
         OP_LUI:   begin c.imm_type = IMM_U; c.alu_op = ALU_PASS_B; c.alu_src = 1'b1;
                         c.reg_write = 1'b1; end
         OP_AUIPC: begin c.imm_type = IMM_U; c.alu_src = 1'b1; c.pc_sel = 1'b1;
                         c.reg_write = 1'b1; end
         default:  ;
      endcase
      return c;
   endfunction

   function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_type_e t);
      logic [31:0] imm;
      imm = {{20{instr[31]}}, instr[31:20]};
      case (t)
         IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm = {instr[31:12], 12'b0};
         IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: ;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/id_regfile_byp.sv
// Register file, two combinational read ports, one write port; x0 hardwired to zero.
// Read latency 0; optional same-cycle forwarding of the WB write to the read ports.
module id_regfile_byp #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_NUM    = 32,
   parameter int BYPASS_EN  = 1,
   parameter int RA_W       = $clog2(REG_NUM)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wb_we,
   input  logic [RA_W-1:0]       wb_rd_addr,
   input  logic [DATA_WIDTH-1:0] wb_rd_data,
   input  logic [RA_W-1:0]       rs1_addr,
   input  logic [RA_W-1:0]       rs2_addr,
   output logic [DATA_WIDTH-1:0] rs1_data,
   output logic [DATA_WIDTH-1:0] rs2_data
);
   import id_pkg::*;

   logic [DATA_WIDTH-1:0] regs_q [REG_NUM];
   logic [DATA_WIDTH-1:0] regs_d [REG_NUM];

   always_comb begin
      regs_d = regs_q;
      if (wb_we && (wb_rd_addr != '0))
         regs_d[wb_rd_addr] = wb_rd_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_NUM; i++)
            regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      rs1_data = regs_q[rs1_addr];
      if (rs1_addr == '0)
         rs1_data = '0;
      else if ((BYPASS_EN != 0) && wb_we && (wb_rd_addr == rs1_addr))
         rs1_data = wb_rd_data;
   end

   always_comb begin
      rs2_data = regs_q[rs2_addr];
      if (rs2_addr == '0)
         rs2_data = '0;
      else if ((BYPASS_EN != 0) && wb_we && (wb_rd_addr == rs2_addr))
         rs2_data = wb_rd_data;
   end

endmodule

// File: rtl/id_stage_pipe.sv
// RV32I decode stage: decode, register read, load-use detection, ID/EX register.
// Latency 1 cycle IF->EX; holds on !ex_ready, one-cycle bubble on load-use, flush wins.
module id_stage_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_NUM    = 32,
   parameter int BYPASS_EN  = 1,
   parameter int CNT_W      = 16,
   parameter int RA_W       = $clog2(REG_NUM)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_valid,
   input  logic [31:0]           if_instr,
   input  logic [DATA_WIDTH-1:0] if_pc,
   output logic                  id_ready,
   input  logic                  flush,
   input  logic                  wb_we,
   input  logic [RA_W-1:0]       wb_rd_addr,
   input  logic [DATA_WIDTH-1:0] wb_rd_data,
   input  logic                  ex_ready,
   output logic                  ex_valid,
   output logic [DATA_WIDTH-1:0] ex_pc,
   output logic [DATA_WIDTH-1:0] ex_rs1_data,
   output logic [DATA_WIDTH-1:0] ex_rs2_data,
   output logic [RA_W-1:0]       ex_rs1_addr,
   output logic [RA_W-1:0]       ex_rs2_addr,
   output logic [RA_W-1:0]       ex_rd_addr,
   output logic [DATA_WIDTH-1:0] ex_imm,
   output logic [2:0]            ex_funct3,
   output logic [6:0]            ex_funct7,
   output logic [2:0]            ex_alu_op,
   output logic                  ex_alu_src,
   output logic                  ex_pc_sel,
   output logic [1:0]            ex_branch,
   output logic                  ex_mem_read,
   output logic                  ex_mem_write,
   output logic                  ex_reg_write,
   output logic [CNT_W-1:0]      stall_cnt
);
   import id_pkg::*;

   ctrl_t                 ctrl;
   logic [RA_W-1:0]       rs1_addr, rs2_addr, rd_addr;
   logic [DATA_WIDTH-1:0] rs1_rdata, rs2_rdata, imm_ext;
   logic [31:0]           imm32;
   logic                  load_use;

   id_ex_t                idex_q, idex_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
   logic [DATA_WIDTH-1:0] imm_q, imm_d;
   logic [RA_W-1:0]       rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d, rd_addr_q, rd_addr_d;
   logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

   always_comb begin
      ctrl     = decode(if_instr[6:0]);
      rs1_addr = RA_W'(if_instr[19:15]);
      rs2_addr = RA_W'(if_instr[24:20]);
      rd_addr  = RA_W'(if_instr[11:7]);
      imm32    = imm_gen(if_instr, ctrl.imm_type);
      imm_ext  = DATA_WIDTH'($signed(imm32));
   end

   id_regfile_byp #(
      .DATA_WIDTH (DATA_WIDTH),
      .REG_NUM    (REG_NUM),
      .BYPASS_EN  (BYPASS_EN),
      .RA_W       (RA_W)
   ) u_regfile (
      .clk        (clk),
      .rst        (rst),
      .wb_we      (wb_we),
      .wb_rd_addr (wb_rd_addr),
      .wb_rd_data (wb_rd_data),
      .rs1_addr   (rs1_addr),
      .rs2_addr   (rs2_addr),
      .rs1_data   (rs1_rdata),
      .rs2_data   (rs2_rdata)
   );

   always_comb begin
      load_use = idex_q.valid && idex_q.mem_read && (rd_addr_q != '0) &&
                 ((ctrl.uses_rs1 && (rs1_addr == rd_addr_q)) ||
                  (ctrl.uses_rs2 && (rs2_addr == rd_addr_q)));
   end

   always_comb begin
      idex_d      = idex_q;
      pc_d        = pc_q;
      rs1_data_d  = rs1_data_q;
      rs2_data_d  = rs2_data_q;
      rs1_addr_d  = rs1_addr_q;
      rs2_addr_d  = rs2_addr_q;
      rd_addr_d   = rd_addr_q;
      imm_d       = imm_q;
      stall_cnt_d = stall_cnt_q;
      id_ready    = 1'b0;
      if (rst) begin
         id_ready = 1'b0;
      end else if (flush) begin
         idex_d.valid = 1'b0;
         id_ready     = 1'b1;
      end else if (!ex_ready) begin
         id_ready = 1'b0;
      end else if (load_use && if_valid) begin
         idex_d.valid = 1'b0;
         if (stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
         idex_d.valid     = if_valid;
         idex_d.funct3    = if_instr[14:12];
         idex_d.funct7    = if_instr[31:25];
         idex_d.alu_op    = ctrl.alu_op;
         idex_d.alu_src   = ctrl.alu_src;
         idex_d.pc_sel    = ctrl.pc_sel;
         idex_d.branch    = ctrl.branch;
         idex_d.mem_read  = ctrl.mem_read;
         idex_d.mem_write = ctrl.mem_write;
         idex_d.reg_write = ctrl.reg_write;
         pc_d             = if_pc;
         rs1_data_d       = rs1_rdata;
         rs2_data_d       = rs2_rdata;
         rs1_addr_d       = rs1_addr;
         rs2_addr_d       = rs2_addr;
         rd_addr_d        = rd_addr;
         imm_d            = imm_ext;
         id_ready         = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idex_q      <= '0;
         pc_q        <= '0;
         rs1_data_q  <= '0;
         rs2_data_q  <= '0;
         rs1_addr_q  <= '0;
         rs2_addr_q  <= '0;
         rd_addr_q   <= '0;
         imm_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         idex_q      <= idex_d;
         pc_q        <= pc_d;
         rs1_data_q  <= rs1_data_d;
         rs2_data_q  <= rs2_data_d;
         rs1_addr_q  <= rs1_addr_d;
         rs2_addr_q  <= rs2_addr_d;
         rd_addr_q   <= rd_addr_d;
         imm_q       <= imm_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign ex_valid     = idex_q.valid;
   assign ex_pc        = pc_q;
   assign ex_rs1_data  = rs1_data_q;
   assign ex_rs2_data  = rs2_data_q;
   assign ex_rs1_addr  = rs1_addr_q;
   assign ex_rs2_addr  = rs2_addr_q;
   assign ex_rd_addr   = rd_addr_q;
   assign ex_imm       = imm_q;
   assign ex_funct3    = idex_q.funct3;
   assign ex_funct7    = idex_q.funct7;
   assign ex_alu_op    = idex_q.alu_op;
   assign ex_alu_src   = idex_q.alu_src;
   assign ex_pc_sel    = idex_q.pc_sel;
   assign ex_branch    = idex_q.branch;
   assign ex_mem_read  = idex_q.mem_read;
   assign ex_mem_write = idex_q.mem_write;
   assign ex_reg_write = idex_q.reg_write;
   assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: scoreboard of expected ID/EX entries, plus a
// second instance with the WB bypass disabled for the forwarding comparison.
module tb_id_stage_pipe;
   localparam int DW = 32, RA_W = 5, CNT_W = 16;

   logic            clk = 1'b0;
   logic            rst, if_valid, flush, wb_we, ex_ready;
   logic [31:0]     if_instr;
   logic [DW-1:0]   if_pc, wb_rd_data;
   logic [RA_W-1:0] wb_rd_addr;

   logic            id_ready, ex_valid, ex_alu_src, ex_pc_sel, ex_mem_read, ex_mem_write, ex_reg_write;
   logic [DW-1:0]   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [RA_W-1:0] ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
   logic [2:0]      ex_funct3, ex_alu_op;
   logic [6:0]      ex_funct7;
   logic [1:0]      ex_branch;
   logic [CNT_W-1:0] stall_cnt;

   logic            nb_id_ready, nb_ex_valid, nb_ex_alu_src, nb_ex_pc_sel, nb_ex_mem_read, nb_ex_mem_write, nb_ex_reg_write;
   logic [DW-1:0]   nb_ex_pc, nb_ex_rs1_data, nb_ex_rs2_data, nb_ex_imm;
   logic [RA_W-1:0] nb_ex_rs1_addr, nb_ex_rs2_addr, nb_ex_rd_addr;
   logic [2:0]      nb_ex_funct3, nb_ex_alu_op;
   logic [6:0]      nb_ex_funct7;
   logic [1:0]      nb_ex_branch;
   logic [CNT_W-1:0] nb_stall_cnt;

   always #5 clk = ~clk;

   id_stage_pipe #(.DATA_WIDTH(DW), .REG_NUM(32), .BYPASS_EN(1), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .id_ready(id_ready), .flush(flush), .wb_we(wb_we), .wb_rd_addr(wb_rd_addr),
      .wb_rd_data(wb_rd_data), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_rs1_addr(ex_rs1_addr),
      .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr), .ex_imm(ex_imm),
      .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_alu_op(ex_alu_op),
      .ex_alu_src(ex_alu_src), .ex_pc_sel(ex_pc_sel), .ex_branch(ex_branch),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
      .stall_cnt(stall_cnt));

   id_stage_pipe #(.DATA_WIDTH(DW), .REG_NUM(32), .BYPASS_EN(0), .CNT_W(CNT_W)) dut_nb (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .id_ready(nb_id_ready), .flush(flush), .wb_we(wb_we), .wb_rd_addr(wb_rd_addr),
      .wb_rd_data(wb_rd_data), .ex_ready(ex_ready), .ex_valid(nb_ex_valid), .ex_pc(nb_ex_pc),
      .ex_rs1_data(nb_ex_rs1_data), .ex_rs2_data(nb_ex_rs2_data), .ex_rs1_addr(nb_ex_rs1_addr),
      .ex_rs2_addr(nb_ex_rs2_addr), .ex_rd_addr(nb_ex_rd_addr), .ex_imm(nb_ex_imm),
      .ex_funct3(nb_ex_funct3), .ex_funct7(nb_ex_funct7), .ex_alu_op(nb_ex_alu_op),
      .ex_alu_src(nb_ex_alu_src), .ex_pc_sel(nb_ex_pc_sel), .ex_branch(nb_ex_branch),
      .ex_mem_read(nb_ex_mem_read), .ex_mem_write(nb_ex_mem_write), .ex_reg_write(nb_ex_reg_write),
      .stall_cnt(nb_stall_cnt));

   typedef struct {
      logic [31:0] pc, rs1, rs2, imm;
      logic [4:0]  rd;
      bit          chk_imm;
      logic        alu_src, reg_write, mem_read, mem_write;
      logic [1:0]  branch;
   } exp_t;

   exp_t sb[$];
   int   pass_cnt = 0, fail_cnt = 0, chk_cnt = 0;

   localparam logic [31:0] I_LW  = 32'h0000_2283;   // lw  x5,0(x0)
   localparam logic [31:0] I_ADD = 32'h0052_8333;   // add x6,x5,x5

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t mk(input logic [31:0] rs1, rs2, input logic [4:0] rd,
                               input logic [31:0] imm, input bit chk_imm,
                               input logic alu_src, reg_write, mem_read, mem_write,
                               input logic [1:0] branch);
      exp_t e;
      e.pc = '0; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.imm = imm; e.chk_imm = chk_imm;
      e.alu_src = alu_src; e.reg_write = reg_write; e.mem_read = mem_read;
      e.mem_write = mem_write; e.branch = branch;
      return e;
   endfunction

   task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
      if_valid = 1'b1;
      if_instr = instr;
      if_pc    = pc;
      e.pc     = pc;
      sb.push_back(e);
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      chk_cnt++;
      assert (sb.size() != 0) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s_sb observed=empty expected=entry", tag);
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_valid"}, 32'(ex_valid), 32'd1);
         chk({tag, "_pc"},    ex_pc, e.pc);
         chk({tag, "_rs1"},   ex_rs1_data, e.rs1);
         chk({tag, "_rs2"},   ex_rs2_data, e.rs2);
         chk({tag, "_rd"},    32'(ex_rd_addr), 32'(e.rd));
         if (e.chk_imm) chk({tag, "_imm"}, ex_imm, e.imm);
         chk({tag, "_ctl"},
             32'({ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}),
             32'({e.alu_src, e.reg_write, e.mem_read, e.mem_write, e.branch}));
      end
   endtask

   initial begin
      rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0;
      wb_we = 1'b0; wb_rd_addr = '0; wb_rd_data = '0; ex_ready = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      #1;
      chk("rst_valid", 32'(ex_valid), 32'd0);
      chk("rst_pc", ex_pc, 32'd0);
      chk("rst_imm", ex_imm, 32'd0);
      chk("rst_rw", 32'(ex_reg_write), 32'd0);
      chk("rst_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_ready", 32'(id_ready), 32'd1);

      // addi x1,x0,5
      issue(32'h0050_0093, 32'h100, mk(0, 0, 1, 5, 1, 1, 1, 0, 0, 0));
      step(); pop_check("addi");

      // add x4,x3,x0 with a same-cycle WB write of x3
      wb_we = 1'b1; wb_rd_addr = 5'd3; wb_rd_data = 32'hDEAD_BEEF;
      issue(32'h0001_8233, 32'h104, mk(32'hDEAD_BEEF, 0, 4, 0, 0, 0, 1, 0, 0, 0));
      step(); wb_we = 1'b0;
      pop_check("byp");
      chk("nobyp_rs1", nb_ex_rs1_data, 32'd0);
      issue(32'h0001_8233, 32'h108, mk(32'hDEAD_BEEF, 0, 4, 0, 0, 0, 1, 0, 0, 0));
      step(); pop_check("rf_rd");
      chk("nobyp_rf_rd", nb_ex_rs1_data, 32'hDEAD_BEEF);

      // load-use: one bubble, then the dependent add
      issue(I_LW, 32'h10C, mk(0, 0, 5, 0, 1, 1, 1, 1, 0, 0));
      step(); pop_check("lw");
      issue(I_ADD, 32'h110, mk(0, 0, 6, 0, 0, 0, 1, 0, 0, 0));
      #1 chk("lu_ready", 32'(id_ready), 32'd0);
      step();
      chk("bubble_valid", 32'(ex_valid), 32'd0);
      chk("bubble_cnt", 32'(stall_cnt), 32'd1);
      chk("bubble_ready", 32'(id_ready), 32'd1);
      step(); pop_check("lu_add");

      // backpressure: hold for 3 cycles
      issue(32'h1200_0393, 32'h114, mk(0, 0, 7, 32'h120, 1, 1, 1, 0, 0, 0));
      step(); pop_check("addi7");
      ex_ready = 1'b0;
      issue(32'h0090_0413, 32'h118, mk(0, 0, 8, 9, 1, 1, 1, 0, 0, 0));
      for (int i = 0; i < 3; i++) begin
         #1 chk("hold_ready", 32'(id_ready), 32'd0);
         step();
         chk("hold_valid", 32'(ex_valid), 32'd1);
         chk("hold_pc", ex_pc, 32'h114);
         chk("hold_imm", ex_imm, 32'h120);
      end
      ex_ready = 1'b1;
      #1 chk("release_ready", 32'(id_ready), 32'd1);
      step(); pop_check("addi8");

      // flush during a load-use stall
      issue(I_LW, 32'h11C, mk(0, 0, 5, 0, 1, 1, 1, 1, 0, 0));
      step(); pop_check("lw2");
      if_instr = I_ADD; if_pc = 32'h120;
      #1 chk("lu2_ready", 32'(id_ready), 32'd0);
      flush = 1'b1;
      #1 chk("flush_ready", 32'(id_ready), 32'd1);
      step();
      flush = 1'b0; if_valid = 1'b0;
      chk("flush_valid", 32'(ex_valid), 32'd0);
      chk("flush_cnt", 32'(stall_cnt), 32'd1);
      step();
      chk("idle_valid", 32'(ex_valid), 32'd0);

      // x0 stays zero: no bypass and no write
      wb_we = 1'b1; wb_rd_addr = 5'd0; wb_rd_data = 32'hFFFF_FFFF;
      issue(32'h0000_04B3, 32'h124, mk(0, 0, 9, 0, 0, 0, 1, 0, 0, 0));
      step(); wb_we = 1'b0;
      pop_check("x0_byp");
      issue(32'h0000_0513, 32'h128, mk(0, 0, 10, 0, 1, 1, 1, 0, 0, 0));
      step(); pop_check("x0_rd");

      // immediate formats and an unknown opcode
      issue(32'hFE00_0EE3, 32'h12C, mk(0, 0, 29, 32'hFFFF_FFFC, 1, 0, 0, 0, 0, 1));
      step(); pop_check("beq");
      issue(32'hFE20_AC23, 32'h130, mk(0, 0, 24, 32'hFFFF_FFF8, 1, 1, 0, 0, 1, 0));
      step(); pop_check("sw");
      issue(32'h8000_05B7, 32'h134, mk(0, 0, 11, 32'h8000_0000, 1, 1, 1, 0, 0, 0));
      step(); pop_check("lui");
      issue(32'h0000_007F, 32'h138, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      step(); pop_check("unk");
      if_valid = 1'b0;
      step();
      chk("end_valid", 32'(ex_valid), 32'd0);
      chk("end_cnt", 32'(stall_cnt), 32'd1);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
